vram_read_buffer: RTL and testbench

//  ISA->VRAM read path; counterpart of the VRAM write buffer. Captures ISA memory reads,

---
 rtl/vram_read_buffer_pkg.sv | 18 +
 rtl/isa_req_sync.sv | 31 +++
 rtl/vram_read_buffer.sv | 226 ++++++++++++++++++++++
 tb/tb_vram_read_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_read_buffer_pkg.sv
// Shared definitions for the VRAM read buffer:
// FSM encodings, wait-counter width and word step.
package vram_read_buffer_pkg;

    localparam int RW_W      = 4;
    localparam int WORD_STEP = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_ARB    = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_PF_ARB = 3'd5,
        S_PF_ACC = 3'd6
    } state_t;

endpackage

// File: rtl/isa_req_sync.sv
// Two-flop synchronizer for an async ISA strobe
// plus rising-edge detect in the clock domain.
module isa_req_sync (
    input  logic clock,
    input  logic RESET,
    input  logic i_req,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resynchronize the strobe and keep one delayed copy for edge detect
    always_ff @(posedge clock or negedge RESET) begin
        if (!RESET) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_req;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule

// File: rtl/vram_read_buffer.sv
// ISA->VRAM read path with write-buffer drain, bus
// arbitration and one-word sequential prefetch.
module vram_read_buffer
    import vram_read_buffer_pkg::*;
#(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int READ_WAIT = 2,
    parameter int PREFETCH  = 1
) (
    input  logic              clock,
    input  logic              RESET,
    input  logic              isaReadReq,
    input  logic [ADDR_W-1:0] addressFromIsa,
    output logic [DATA_W-1:0] dataToIsa,
    output logic              isaReady,
    input  logic              wbEmpty,
    input  logic              free,
    input  logic [DATA_W-1:0] vramDataIn,
    output logic [ADDR_W-1:0] vramAddress,
    output logic              read_cmd,
    output logic              chip_select,
    output logic              READBUF_IO_EN,
    output logic              pfHit
);

    localparam logic [RW_W-1:0]   LP_WAIT = RW_W'(READ_WAIT);
    localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(WORD_STEP);
    localparam logic              LP_PF   = (PREFETCH != 0);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_pfAddr;
    logic [DATA_W-1:0]   r_pfData;
    logic                r_pfValid;
    logic                r_pfPend;
    logic                r_reqPend;
    logic [RW_W-1:0]     r_ctr;
    logic [DATA_W-1:0]   r_dataToIsa;
    logic                r_isaReady;
    logic                r_pfHit;
    logic [ADDR_W-1:0]   r_vramAddress;

    logic                w_req;
    logic                w_rise;
    logic                w_newReq;
    logic                w_stale;
    logic [ADDR_W-2:0]   w_cmpWord;
    logic                w_hit;
    logic                w_pfWant;
    logic                w_inAcc;
    logic                w_bus;
    logic                w_ctrDone;
    logic                w_idleLike;
    logic                w_take;
    logic                w_abort;
    logic                w_startDem;
    logic                w_startPf;
    logic                w_count;
    logic                w_dem;
    logic                w_pfFill;

    isa_req_sync u_sync (
        .clock   (clock),
        .RESET   (RESET),
        .i_req   (isaReadReq),
        .o_level (w_req),
        .o_rise  (w_rise)
    );

    assign w_newReq   = w_rise | r_reqPend;
    assign w_stale    = w_rise | r_reqPend;
    assign w_cmpWord  = w_rise ? addressFromIsa[ADDR_W-1:1]
                               : r_addr[ADDR_W-1:1];
    assign w_hit      = r_pfValid & wbEmpty
                      & (w_cmpWord == r_pfAddr[ADDR_W-1:1]);
    assign w_pfWant   = LP_PF & ~r_pfValid & r_pfPend;
    assign w_inAcc    = (r_state == S_ACCESS) | (r_state == S_PF_ACC);
    assign w_bus      = w_inAcc & free;
    assign w_ctrDone  = (r_ctr == LP_WAIT);
    assign w_idleLike = (r_state == S_IDLE) | (r_state == S_PF_ARB);

    // Bus strobes follow the grant combinationally so a lost grant
    // releases the bus in the same clock
    assign chip_select   = ~w_bus;
    assign read_cmd      = ~w_bus;
    assign READBUF_IO_EN = w_bus;
    assign dataToIsa     = r_dataToIsa;
    assign isaReady      = r_isaReady;
    assign pfHit         = r_pfHit;
    assign vramAddress   = r_vramAddress;

    // FSM state register
    always_ff @(posedge clock or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_next     = r_state;
        w_take     = 1'b0;
        w_abort    = 1'b0;
        w_startDem = 1'b0;
        w_startPf  = 1'b0;
        w_dem      = 1'b0;
        w_pfFill   = 1'b0;
        w_count    = w_bus & ~w_ctrDone;
        unique case (r_state)
            S_IDLE, S_PF_ARB: begin
                if (w_newReq) begin
                    w_take = 1'b1;
                    w_next = w_hit ? S_DONE : S_DRAIN;
                end else if (r_state == S_PF_ARB) begin
                    if (free && wbEmpty) begin
                        w_startPf = 1'b1;
                        w_next    = S_PF_ACC;
                    end
                end else if (w_pfWant) begin
                    w_next = S_PF_ARB;
                end
            end
            S_DRAIN: begin
                if (!w_req) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (wbEmpty) begin
                    w_next = S_ARB;
                end
            end
            S_ARB: begin
                if (!w_req || w_stale) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (free) begin
                    w_startDem = 1'b1;
                    w_next     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!free) begin
                    w_next = S_ARB;
                end else if (w_ctrDone) begin
                    if (!w_req || w_stale) begin
                        w_abort = 1'b1;
                        w_next  = S_IDLE;
                    end else begin
                        w_dem  = 1'b1;
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!w_req) w_next = S_IDLE;
            end
            S_PF_ACC: begin
                if (!free) begin
                    w_next = S_IDLE;
                end else if (w_ctrDone) begin
                    w_pfFill = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Address, prefetch, wait counter and ISA-side registers
    always_ff @(posedge clock or negedge RESET) begin
        if (!RESET) begin
            r_addr        <= '0;
            r_pfAddr      <= '0;
            r_pfData      <= '0;
            r_pfValid     <= 1'b0;
            r_pfPend      <= 1'b0;
            r_reqPend     <= 1'b0;
            r_ctr         <= '0;
            r_dataToIsa   <= '0;
            r_isaReady    <= 1'b1;
            r_pfHit       <= 1'b0;
            r_vramAddress <= '0;
        end else begin
            r_pfHit <= 1'b0;
            if (w_rise) r_addr <= addressFromIsa;
            if (w_take) begin
                r_reqPend <= 1'b0;
                if (w_hit) begin
                    r_dataToIsa <= r_pfData;
                    r_isaReady  <= 1'b1;
                    r_pfHit     <= 1'b1;
                end else begin
                    r_isaReady <= 1'b0;
                end
            end
            if (w_abort && !r_reqPend) r_isaReady <= 1'b1;
            if (w_startDem) begin
                r_vramAddress <= r_addr;
                r_ctr         <= '0;
            end
            if (w_startPf) begin
                r_vramAddress <= r_pfAddr;
                r_ctr         <= '0;
            end
            if (w_count) r_ctr <= r_ctr + RW_W'(1);
            if (w_dem) begin
                r_dataToIsa <= vramDataIn;
                r_isaReady  <= 1'b1;
                r_pfAddr    <= r_addr + LP_STEP;
                r_pfPend    <= LP_PF;
                r_pfValid   <= 1'b0;
            end
            if (w_pfFill) begin
                r_pfData  <= vramDataIn;
                r_pfValid <= 1'b1;
                r_pfPend  <= 1'b0;
            end
            if (w_rise && !w_idleLike) begin
                r_reqPend  <= 1'b1;
                r_isaReady <= 1'b0;
            end
            if (!wbEmpty) r_pfValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vram_read_buffer.sv
// Directed bench for vram_read_buffer with a
// small address-derived VRAM content model.
module tb_vram_read_buffer;

    logic        clock = 1'b0;
    logic        RESET;
    logic        isaReadReq;
    logic [19:0] addressFromIsa;
    logic [15:0] dataToIsa;
    logic        isaReady;
    logic        wbEmpty;
    logic        free;
    logic [15:0] vramDataIn;
    logic [19:0] vramAddress;
    logic        read_cmd;
    logic        chip_select;
    logic        READBUF_IO_EN;
    logic        pfHit;

    int          checks = 0;
    int          fails  = 0;
    int          low_at;
    int          ce_cyc;
    int          hit_cnt;
    int          bus_bad;
    int          ce_wb_low;
    bit          low_seen;
    bit          rd_done;
    logic [19:0] ce_addr;

    vram_read_buffer dut (
        .clock          (clock),
        .RESET          (RESET),
        .isaReadReq     (isaReadReq),
        .addressFromIsa (addressFromIsa),
        .dataToIsa      (dataToIsa),
        .isaReady       (isaReady),
        .wbEmpty        (wbEmpty),
        .free           (free),
        .vramDataIn     (vramDataIn),
        .vramAddress    (vramAddress),
        .read_cmd       (read_cmd),
        .chip_select    (chip_select),
        .READBUF_IO_EN  (READBUF_IO_EN),
        .pfHit          (pfHit)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] vram_model(input logic [19:0] a);
        case (a)
            20'h12340: return 16'hBEEF;
            20'h12342: return 16'hCAFE;
            default:   return a[15:0] ^ 16'h5A5A;
        endcase
    endfunction

    assign vramDataIn = vram_model(vramAddress);

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        low_at    = 0;
        ce_cyc    = 0;
        hit_cnt   = 0;
        bus_bad   = 0;
        ce_wb_low = 0;
        low_seen  = 1'b0;
        ce_addr   = 20'hxxxxx;
    endtask

    task automatic sample_bus();
        if (read_cmd !== chip_select || READBUF_IO_EN !== ~chip_select)
            bus_bad++;
        if (chip_select === 1'b0) begin
            ce_cyc++;
            ce_addr = vramAddress;
        end
        if (pfHit === 1'b1) hit_cnt++;
    endtask

    task automatic do_read(input logic [19:0] a, input int wb_low,
                           input bit drop_free);
        bit dropped = 1'b0;
        bit restore = 1'b0;
        clear_stats();
        rd_done        = 1'b0;
        wbEmpty        = (wb_low == 0);
        addressFromIsa = a;
        isaReadReq     = 1'b1;
        for (int k = 1; k <= 60 && !rd_done; k++) begin
            @(negedge clock);
            sample_bus();
            if (!wbEmpty && chip_select === 1'b0) ce_wb_low++;
            if (isaReady === 1'b0 && !low_seen) begin
                low_seen = 1'b1;
                low_at   = k;
            end
            if (pfHit === 1'b1) rd_done = 1'b1;
            if (low_seen && isaReady === 1'b1) rd_done = 1'b1;
            if (restore) begin
                free    = 1'b1;
                restore = 1'b0;
            end
            if (drop_free && !dropped && chip_select === 1'b0) begin
                free = 1'b0;
                #1;
                check("free_drop_bus",
                      {29'd0, chip_select, read_cmd, READBUF_IO_EN}, 3'b110);
                dropped = 1'b1;
                restore = 1'b1;
            end
            if (k >= wb_low) wbEmpty = 1'b1;
        end
        check("read_done", {31'd0, rd_done}, 1);
        free    = 1'b1;
        wbEmpty = 1'b1;
    endtask

    task automatic idle_wait(input int n);
        clear_stats();
        isaReadReq = 1'b0;
        repeat (n) begin
            @(negedge clock);
            sample_bus();
        end
    endtask

    initial begin
        bit found;
        RESET          = 1'b0;
        isaReadReq     = 1'b0;
        addressFromIsa = '0;
        wbEmpty        = 1'b1;
        free           = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_ready", {31'd0, isaReady}, 1);
        check("rst_bus", {28'd0, read_cmd, chip_select, READBUF_IO_EN, pfHit},
              4'b1100);
        check("rst_data", {16'd0, dataToIsa}, 0);
        check("rst_vaddr", {12'd0, vramAddress}, 0);
        RESET = 1'b1;
        repeat (2) @(negedge clock);

        do_read(20'h12340, 0, 1'b0);
        check("t1_low_at", low_at, 3);
        check("t1_ce_cycles", ce_cyc, 3);
        check("t1_vaddr", {12'd0, ce_addr}, 32'h12340);
        check("t1_data", {16'd0, dataToIsa}, 32'hBEEF);
        check("t1_bus", bus_bad, 0);
        idle_wait(12);
        check("pf1_ce_cycles", ce_cyc, 3);
        check("pf1_vaddr", {12'd0, ce_addr}, 32'h12342);

        do_read(20'h12342, 0, 1'b0);
        check("t2_never_low", {31'd0, low_seen}, 0);
        check("t2_hit", hit_cnt, 1);
        check("t2_ce_cycles", ce_cyc, 0);
        check("t2_data", {16'd0, dataToIsa}, 32'hCAFE);
        idle_wait(12);
        check("t2_hit_pulse", hit_cnt, 0);
        check("t2_no_refetch", ce_cyc, 0);

        do_read(20'h12342, 10, 1'b0);
        check("t3_miss", {31'd0, low_seen}, 1);
        check("t3_hit", hit_cnt, 0);
        check("t3_ce_wb_low", ce_wb_low, 0);
        check("t3_ce_cycles", ce_cyc, 3);
        check("t3_data", {16'd0, dataToIsa}, 32'hCAFE);
        idle_wait(12);
        check("pf3_vaddr", {12'd0, ce_addr}, 32'h12344);

        wbEmpty = 1'b0;
        repeat (2) @(negedge clock);
        wbEmpty = 1'b1;
        @(negedge clock);
        do_read(20'h12344, 0, 1'b0);
        check("inv_miss", {31'd0, low_seen}, 1);
        check("inv_hit", hit_cnt, 0);
        check("inv_data", {16'd0, dataToIsa}, 32'h791E);
        idle_wait(12);

        do_read(20'h00100, 0, 1'b1);
        check("t4_ce_cycles", ce_cyc, 4);
        check("t4_data", {16'd0, dataToIsa}, 32'h5B5A);
        check("t4_bus", bus_bad, 0);
        idle_wait(12);

        do_read(20'hFFFFE, 0, 1'b0);
        check("t5_data", {16'd0, dataToIsa}, 32'hA5A4);
        idle_wait(12);
        check("t5_pf_ce", ce_cyc, 3);
        check("t5_pf_wrap", {12'd0, ce_addr}, 32'h00000);

        addressFromIsa = 20'h00200;
        isaReadReq     = 1'b1;
        found          = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clock);
            if (chip_select === 1'b0) found = 1'b1;
        end
        check("rst_mid_found", {31'd0, found}, 1);
        RESET = 1'b0;
        #1;
        check("rst_mid_ready", {31'd0, isaReady}, 1);
        check("rst_mid_bus",
              {28'd0, read_cmd, chip_select, READBUF_IO_EN, pfHit}, 4'b1100);
        check("rst_mid_data", {16'd0, dataToIsa}, 0);
        check("rst_mid_vaddr", {12'd0, vramAddress}, 0);
        isaReadReq = 1'b0;
        repeat (2) @(negedge clock);
        RESET = 1'b1;
        repeat (3) @(negedge clock);

        wbEmpty        = 1'b0;
        addressFromIsa = 20'h00300;
        isaReadReq     = 1'b1;
        found          = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clock);
            if (isaReady === 1'b0) found = 1'b1;
        end
        check("t6_stretch", {31'd0, found}, 1);
        idle_wait(6);
        check("t6_ready", {31'd0, isaReady}, 1);
        check("t6_no_ce", ce_cyc, 0);
        wbEmpty = 1'b1;
        idle_wait(6);
        check("t6_no_stray", ce_cyc, 0);
        do_read(20'h00300, 0, 1'b0);
        check("t6_miss", {31'd0, low_seen}, 1);
        check("t6_hit", hit_cnt, 0);
        check("t6_data", {16'd0, dataToIsa}, 32'h595A);
        idle_wait(4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
